// File: rtl/sramx_arb_pkg.sv
// Shared types for the sramx two-to-one arbiter: request/response bundles,
// the arbiter FSM state encoding and the owner encoding.
package sramx_arb_pkg;

  // Request from a requester (or merged request to the downstream slave).
  typedef struct packed {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sramx_req_t;

  // Response from the downstream slave (or routed back to a requester).
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
  } sramx_resp_t;

  // IDLE: nothing pending; ADDR: owner locked, waiting addr_ok;
  // DATA: address accepted, waiting data_ok.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } sramx_arb_state_t;

  // Which requester owns (or is selected for) the shared port.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    I    = 2'd1,
    D    = 2'd2
  } sramx_arb_owner_t;

  // Returns the opposite requester; used to advance the round-robin pointer.
  function automatic sramx_arb_owner_t sramx_arb_other(input sramx_arb_owner_t o);
    return (o == D) ? I : D;
  endfunction

endpackage

// File: rtl/sramx_arb_pick.sv
// Grant selection between the instruction-side and data-side requests.
// Build option SRAMX_ARB_RR_EN: when defined, simultaneous requests are
// resolved by the round-robin pointer; otherwise D always beats I.
module sramx_arb_pick
  import sramx_arb_pkg::*;
(
  input  logic             i_req,
  input  logic             d_req,
  input  sramx_arb_owner_t rr_ptr,
  output sramx_arb_owner_t grant
);

`ifndef SRAMX_ARB_RR_EN
  // The pointer has no meaning under fixed priority; tie it off quietly.
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;
`endif

  // Choose the winner among the active requests; a lone request always wins.
  always_comb begin
    grant = NONE;
    if (i_req && d_req) begin
`ifdef SRAMX_ARB_RR_EN
      grant = rr_ptr;
`else
      grant = D;
`endif
    end else if (d_req) begin
      grant = D;
    end else if (i_req) begin
      grant = I;
    end
  end

endmodule

// File: rtl/sramx_arbiter.sv
// Two-to-one sramx arbiter: shares one downstream sramx port between the
// instruction-side and data-side requesters, one transaction at a time.
// Request and response paths are combinational; the FSM only tracks which
// requester owns the port and whether its address has been accepted.
// Build option SRAMX_ARB_RR_EN selects round-robin instead of D-over-I.
module sramx_arbiter
  import sramx_arb_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  sramx_req_t  isreq,
  output sramx_resp_t isresp,
  input  sramx_req_t  dsreq,
  output sramx_resp_t dsresp,
  output sramx_req_t  msreq,
  input  sramx_resp_t msresp
);

  sramx_arb_state_t state_reg;
  sramx_arb_owner_t owner_reg;
  sramx_arb_owner_t rr_ptr;
  sramx_arb_owner_t grant;
  sramx_arb_owner_t sel;

`ifdef SRAMX_ARB_RR_EN
  sramx_arb_owner_t rr_ptr_reg;
  assign rr_ptr = rr_ptr_reg;

  // Pointer flips on every grant decision made in IDLE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr_reg <= I;
    end else if (state_reg == IDLE && grant != NONE) begin
      rr_ptr_reg <= sramx_arb_other(rr_ptr_reg);
    end
  end
`else
  assign rr_ptr = I;
`endif

  sramx_arb_pick u_pick (
    .i_req  (isreq.req),
    .d_req  (dsreq.req),
    .rr_ptr (rr_ptr),
    .grant  (grant)
  );

  // Port selected this cycle: the live winner in IDLE, else the locked owner.
  always_comb begin
    sel = NONE;
    if (resetn) begin
      case (state_reg)
        IDLE:    sel = grant;
        ADDR,
        DATA:    sel = owner_reg;
        default: sel = NONE;
      endcase
    end
  end

  // Forward the selected request; nothing is requested while waiting data.
  always_comb begin
    msreq = '0;
    if (state_reg != DATA) begin
      case (sel)
        I:       msreq = isreq;
        D:       msreq = dsreq;
        default: msreq = '0;
      endcase
    end
  end

  // Handshakes go to the selected port only; read data is broadcast.
  always_comb begin
    isresp       = '0;
    dsresp       = '0;
    isresp.rdata = msresp.rdata;
    dsresp.rdata = msresp.rdata;
    if (sel == I) begin
      isresp.addr_ok = msresp.addr_ok;
      isresp.data_ok = msresp.data_ok;
    end else if (sel == D) begin
      dsresp.addr_ok = msresp.addr_ok;
      dsresp.data_ok = msresp.data_ok;
    end
  end

  // Transaction FSM; owner is locked when leaving IDLE and cleared on return.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
      owner_reg <= NONE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant != NONE) begin
            if (msresp.addr_ok && msresp.data_ok) begin
              state_reg <= IDLE;
              owner_reg <= NONE;
            end else if (msresp.addr_ok) begin
              state_reg <= DATA;
              owner_reg <= grant;
            end else begin
              state_reg <= ADDR;
              owner_reg <= grant;
            end
          end
        end
        ADDR: begin
          if (msresp.addr_ok) begin
            if (msresp.data_ok) begin
              state_reg <= IDLE;
              owner_reg <= NONE;
            end else begin
              state_reg <= DATA;
            end
          end
        end
        DATA: begin
          if (msresp.data_ok) begin
            state_reg <= IDLE;
            owner_reg <= NONE;
          end
        end
        default: begin
          state_reg <= IDLE;
          owner_reg <= NONE;
        end
      endcase
    end
  end

endmodule
